// File: rtl/pipe_run_monitor.sv
// rtl/pipe_run_monitor.sv - run controller and result monitor for the 5-stage pipeline core
// Optional feature: define RUN_MON_TRACE_EN to add the Last_Chg_Cnt trace output.
module pipe_run_monitor #(
    parameter int DATA_W        = 32,
    parameter int NUM_CH        = 2,
    parameter int RST_CYCLES    = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 4096,
    parameter int CNT_W         = 16
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Start,
    input  logic [NUM_CH*DATA_W-1:0] Exp_Data,
    input  logic [NUM_CH*DATA_W-1:0] Obs_Data,
    output logic                     Core_Rst,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Pass,
    output logic                     Timeout,
    output logic [NUM_CH-1:0]        Fail_Mask,
    output logic [CNT_W-1:0]         Cycle_Cnt
`ifdef RUN_MON_TRACE_EN
    ,
    output logic [CNT_W-1:0]         Last_Chg_Cnt
`endif
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t                     state, state_nxt;
    logic [RW-1:0]              rst_cnt;
    logic [SW-1:0]              stab_cnt;
    logic [NUM_CH*DATA_W-1:0]   prev;
    logic                       prev_valid;
    logic [NUM_CH-1:0]          mismatch;
    logic                       same;
    logic                       start_acc;
    logic                       stable_end;
    logic                       timeout_end;
    logic                       core_rst_nxt;
    logic                       busy_nxt;
    logic                       done_nxt;

    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mismatch[i] = Obs_Data[i*DATA_W +: DATA_W] != Exp_Data[i*DATA_W +: DATA_W];
        end
    end

    // prev is meaningless on the first RUN edge, so prev_valid gates the stability test
    assign same        = (Obs_Data == prev);
    assign start_acc   = Start && (state == S_IDLE || state == S_DONE);
    assign stable_end  = (state == S_RUN) && prev_valid && same &&
                         (stab_cnt == SW'(STABLE_CYCLES - 1));
    assign timeout_end = (state == S_RUN) && (Cycle_Cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_IDLE;
            Core_Rst <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            Core_Rst <= core_rst_nxt;
            Busy     <= busy_nxt;
            Done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_acc) state_nxt = S_RESET;
            S_RESET: if (rst_cnt == RW'(RST_CYCLES - 1)) state_nxt = S_RUN;
            S_RUN:   if (stable_end || timeout_end) state_nxt = S_DONE;
            S_DONE:  if (start_acc) state_nxt = S_RESET;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        core_rst_nxt = (state_nxt == S_IDLE) || (state_nxt == S_RESET);
        busy_nxt     = (state_nxt == S_RESET) || (state_nxt == S_RUN);
        done_nxt     = (state_nxt == S_DONE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rst_cnt      <= '0;
            stab_cnt     <= '0;
            prev         <= '0;
            prev_valid   <= 1'b0;
            Cycle_Cnt    <= '0;
            Pass         <= 1'b0;
            Timeout      <= 1'b0;
            Fail_Mask    <= '0;
`ifdef RUN_MON_TRACE_EN
            Last_Chg_Cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_acc) begin
                        rst_cnt      <= '0;
                        stab_cnt     <= '0;
                        prev_valid   <= 1'b0;
                        Cycle_Cnt    <= '0;
                        Pass         <= 1'b0;
                        Timeout      <= 1'b0;
                        Fail_Mask    <= '0;
`ifdef RUN_MON_TRACE_EN
                        Last_Chg_Cnt <= '0;
`endif
                    end
                end
                S_RESET: rst_cnt <= rst_cnt + RW'(1);
                S_RUN: begin
                    Cycle_Cnt  <= Cycle_Cnt + CNT_W'(1);
                    prev       <= Obs_Data;
                    prev_valid <= 1'b1;
                    stab_cnt   <= (prev_valid && same) ? stab_cnt + SW'(1) : '0;
`ifdef RUN_MON_TRACE_EN
                    if (!prev_valid || !same) Last_Chg_Cnt <= Cycle_Cnt + CNT_W'(1);
`endif
                    // stable end takes priority when both ends coincide
                    if (stable_end) begin
                        Fail_Mask <= mismatch;
                        Pass      <= ~|mismatch;
                        Timeout   <= 1'b0;
                    end else if (timeout_end) begin
                        Fail_Mask <= mismatch;
                        Pass      <= 1'b0;
                        Timeout   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_run_monitor.sv
// tb/tb_pipe_run_monitor.sv - self-checking bench for pipe_run_monitor
module tb_pipe_run_monitor;

    localparam int DW  = 32;
    localparam int NC  = 2;
    localparam int RST = 2;
    localparam int STB = 4;
    localparam int TO  = 64;
    localparam int CW  = 16;

    logic            Clk = 1'b0;
    logic            Rst_n;
    logic            Start;
    logic [NC*DW-1:0] Exp_Data;
    logic [NC*DW-1:0] Obs_Data;
    logic            Core_Rst, Busy, Done, Pass, Timeout;
    logic [NC-1:0]   Fail_Mask;
    logic [CW-1:0]   Cycle_Cnt;
`ifdef RUN_MON_TRACE_EN
    logic [CW-1:0]   Last_Chg_Cnt;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    pipe_run_monitor #(
        .DATA_W(DW), .NUM_CH(NC), .RST_CYCLES(RST), .STABLE_CYCLES(STB),
        .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Exp_Data(Exp_Data), .Obs_Data(Obs_Data),
        .Core_Rst(Core_Rst), .Busy(Busy), .Done(Done), .Pass(Pass), .Timeout(Timeout),
        .Fail_Mask(Fail_Mask), .Cycle_Cnt(Cycle_Cnt)
`ifdef RUN_MON_TRACE_EN
        , .Last_Chg_Cnt(Last_Chg_Cnt)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: a run is the list of Obs samples taken after the reset window;
    // it ends once the last STB+1 samples agree or the list reaches TO entries.
    logic [NC*DW-1:0] samples[$];
    bit               m_active, m_finished;
    int               m_cyc, m_s;
    bit               m_pass, m_to;
    logic [NC-1:0]    m_fm;
    int               m_lc;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_active = 0; m_finished = 0; m_cyc = 0; m_s = 0;
            m_pass = 0; m_to = 0; m_fm = '0; m_lc = 0;
            samples.delete();
        end else begin
            m_cyc++;
            if ((!m_active || m_finished) && Start) begin
                m_active = 1; m_finished = 0; m_s = m_cyc;
                m_pass = 0; m_to = 0; m_fm = '0; m_lc = 0;
                samples.delete();
            end else if (m_active && !m_finished && m_cyc > m_s + RST) begin
                int n;
                bit stable;
                logic [NC*DW-1:0] cur;
                cur = Obs_Data;
                samples.push_back(cur);
                n = samples.size();
                if (n == 1 || samples[n-2] != cur) m_lc = n;
                stable = (n >= STB + 1);
                for (int k = 1; k <= STB; k++)
                    if (stable && samples[n-1-k] != cur) stable = 0;
                if (stable || n == TO) begin
                    m_finished = 1;
                    for (int c = 0; c < NC; c++)
                        m_fm[c] = cur[c*DW +: DW] != Exp_Data[c*DW +: DW];
                    m_to   = !stable;
                    m_pass = stable && (m_fm == '0);
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("core_rst", Core_Rst, !m_active || (m_cyc < m_s + RST));
            check("busy", Busy, m_active && !m_finished);
            check("done", Done, m_finished);
            check("cycle_cnt", Cycle_Cnt, samples.size());
`ifdef RUN_MON_TRACE_EN
            check("last_chg_cnt", Last_Chg_Cnt, m_lc);
`endif
            if (m_finished) begin
                check("pass", Pass, m_pass);
                check("timeout", Timeout, m_to);
                check("fail_mask", Fail_Mask, m_fm);
            end
        end
    end

    task automatic start_pulse();
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
    endtask

    task automatic count_core_rst(input string name);
        int n = 0;
        while (Core_Rst && n < 10) begin @(negedge Clk); n++; end
        check(name, n, RST);
    endtask

    task automatic wait_done(input int budget, input bit toggle, input string name);
        int n = 0;
        while (!Done && n < budget) begin
            if (toggle) Obs_Data[0] = ~Obs_Data[0];
            @(negedge Clk); n++;
        end
        check(name, Done, 1'b1);
    endtask

    task automatic run_until(input int target, input bit toggle, input string name);
        int n = 0;
        while (Cycle_Cnt != CW'(target) && n < 200) begin
            if (toggle) Obs_Data[0] = ~Obs_Data[0];
            @(negedge Clk); n++;
        end
        check(name, Cycle_Cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b1; Start = 1'b0;
        Exp_Data = {32'd7, 32'd5}; Obs_Data = {32'd7, 32'd5};
        #3 Rst_n = 1'b0;
        #1;
        check("t1_core_rst", Core_Rst, 1'b1);
        check("t1_busy", Busy, 1'b0);
        check("t1_done", Done, 1'b0);
        check("t1_pass", Pass, 1'b0);
        check("t1_fail_mask", Fail_Mask, 2'b00);
        check("t1_cycle_cnt", Cycle_Cnt, 0);
        chk_en = 1'b1;
        @(negedge Clk); @(negedge Clk); Rst_n = 1'b1;
        repeat (3) @(negedge Clk);

        start_pulse();
        count_core_rst("t2_core_rst_clks");
        wait_done(40, 0, "t2_done");
        check("t2_cycle_cnt", Cycle_Cnt, 5);
        check("t2_pass", Pass, 1'b1);
        check("t2_fail_mask", Fail_Mask, 2'b00);
        repeat (3) @(negedge Clk);
        check("t2_hold_cnt", Cycle_Cnt, 5);
        check("t2_hold_core_rst", Core_Rst, 1'b0);

        Exp_Data = {32'd8, 32'd5};
        start_pulse();
        count_core_rst("t3_core_rst_clks");
        wait_done(40, 0, "t3_done");
        check("t3_cycle_cnt", Cycle_Cnt, 5);
        check("t3_pass", Pass, 1'b0);
        check("t3_fail_mask", Fail_Mask, 2'b10);
        check("t3_timeout", Timeout, 1'b0);

        Exp_Data = {32'd7, 32'd5};
        start_pulse();
        wait_done(100, 1, "t4_done");
        check("t4_cycle_cnt", Cycle_Cnt, 64);
        check("t4_timeout", Timeout, 1'b1);
        check("t4_pass", Pass, 1'b0);

        start_pulse();
        run_until(6, 1, "t5_reach6");
        start_pulse();
        check("t5_start_ignored_busy", Busy, 1'b1);
        check("t5_start_ignored_core_rst", Core_Rst, 1'b0);
        run_until(10, 1, "t5_reach10");
        #2 Rst_n = 1'b0;
        #1;
        check("t5_core_rst", Core_Rst, 1'b1);
        check("t5_cycle_cnt", Cycle_Cnt, 0);
        check("t5_busy", Busy, 1'b0);
        @(negedge Clk); Rst_n = 1'b1;
        @(negedge Clk);
        check("t5_idle_core_rst", Core_Rst, 1'b1);
        check("t5_idle_done", Done, 1'b0);

        Obs_Data = {32'd7, 32'd5};
        Exp_Data = {32'd7, 32'd100};
        start_pulse();
        run_until(11, 1, "t6_reach11");
        Obs_Data = {32'd7, 32'd100};
        wait_done(40, 0, "t6_done");
        check("t6_cycle_cnt", Cycle_Cnt, 16);
        check("t6_pass", Pass, 1'b1);
`ifdef RUN_MON_TRACE_EN
        check("t6_last_chg_cnt", Last_Chg_Cnt, 12);
`endif
        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
